// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for generator and checker.
package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 27;
    localparam int TAP_B    = 30;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // hist[i] holds the bit from i+1 steps ago; returns the predicted next bit.
    function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_err_counter.sv
// Saturating counter with synchronous clear (clear beats increment).
// Latency: count updates one cycle after inc/clr; sat decodes the registered count.
// Backpressure: none; inc is ignored once the count is all-ones.
module prbs31_err_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !sat) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-syncs, locks, counts errors; bit_count port under PRBS31_CHECKER_BITCNT_EN.
// Latency: all outputs registered, one cycle after the sampled valid bit.
// Backpressure: none; bit_vld qualifies each input bit and all state holds while it is low.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 16,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef PRBS31_CHECKER_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic             err_sat
);

    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    state_e              state_q, state_d;
    logic [PRBS_LEN-1:0] hist_q, hist_d;
    logic [4:0]          fill_q, fill_d;
    logic [7:0]          good_q, good_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic                locked_q, err_pulse_q, err_pulse_d;

    logic exp_bit;
    logic mism;
    logic counted_err;

    assign exp_bit     = prbs31_next(hist_q);
    assign mism        = bit_in ^ exp_bit;
    assign counted_err = bit_vld && (state_q == LOCKED) && mism;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        if (bit_vld) begin
            case (state_q)
                SEED: begin
                    hist_d = {hist_q[PRBS_LEN-2:0], bit_in};
                    if (fill_q == 5'(PRBS_LEN - 1)) begin
                        fill_d  = '0;
                        state_d = HUNT;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                HUNT: begin
                    hist_d = {hist_q[PRBS_LEN-2:0], bit_in};
                    if (mism) begin
                        good_d = '0;
                    end else if (good_q == 8'(LOCK_CNT - 1)) begin
                        // An all-zero history predicts zeros forever; never lock onto it.
                        good_d = '0;
                        if (hist_q != '0) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a line error never corrupts history.
                    hist_d      = {hist_q[PRBS_LEN-2:0], exp_bit};
                    err_pulse_d = mism;
                    win_d       = win_q + 1'b1;
                    werr_d      = ((win_q == WIN_W'(WIN_LEN - 1)) ? '0 : werr_q) + WERR_W'(mism);
                    if (werr_d == WERR_W'(LOSS_THRESH)) begin
                        state_d = SEED;
                        fill_d  = '0;
                        good_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            hist_q      <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

    prbs31_err_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (counted_err),
        .clr   (clr_err),
        .count (err_count),
        .sat   (err_sat)
    );

`ifdef PRBS31_CHECKER_BITCNT_EN
    logic bit_cnt_inc;
    logic bit_cnt_sat;

    assign bit_cnt_inc = bit_vld && (state_q == LOCKED);

    prbs31_err_counter #(.W(32)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_cnt_inc),
        .clr   (clr_err),
        .count (bit_count),
        .sat   (bit_cnt_sat)
    );
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed self-checking bench for prbs31_checker.
module tb_prbs31_checker;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_vld;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        err_sat;
`ifdef PRBS31_CHECKER_BITCNT_EN
    logic [31:0] bit_count;
`endif

    int          checks;
    int          errors;
    logic [30:0] g;
    int          nlk;

    prbs31_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef PRBS31_CHECKER_BITCNT_EN
        .bit_count (bit_count),
`endif
        .err_sat   (err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are read at the same point.
    task automatic drive(input logic b, input logic v, input logic c);
        bit_in  = b;
        bit_vld = v;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic flip, input logic c);
        logic b;
        b = g[27] ^ g[30];
        g = {g[29:0], b};
        if (locked) nlk++;
        drive(b ^ flip, 1'b1, c);
    endtask

    task automatic idle();
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        clr_err = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0d want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (err_sat !== 1'b0) begin errors++; $display("FAIL reset_err_sat got %0d want 0", err_sat); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        int lock_at = 0;
        int drops = 0;
        int pulses = 0;
        g = 31'd1;
        for (int i = 1; i <= 200; i++) begin
            send_bit(1'b0, 1'b0);
            if (locked === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        nlk = 0;
        // Seen right after the 95th bit's edge, i.e. during cycle 31 + 64 + 1.
        checks++; if (lock_at != 95) begin errors++; $display("FAIL clean_lock_time got %0d want 95 (0 = timeout)", lock_at); end
        for (int i = 0; i < 10000; i++) begin
            send_bit(1'b0, 1'b0);
            if (locked !== 1'b1) drops++;
            if (err_pulse !== 1'b0) pulses++;
        end
        checks++; if (drops != 0) begin errors++; $display("FAIL clean_lock_drops got %0d want 0", drops); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clean_err_pulses got %0d want 0", pulses); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        send_bit(1'b1, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse_timing got %0d want 1", err_pulse); end
        pulses = 1;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 1'b0);
            if (err_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", pulses); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_count got %0d want 1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %0d want 1", locked); end
    endtask

    task automatic test_burst_loss();
        int relock = 0;
        send_bit(1'b0, 1'b1);
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL burst_clr got %0d want 0", err_count); end
        // Align to the start of a loss window so all 16 errors share one window.
        while ((nlk % 256) != 0) send_bit(1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            send_bit(1'b1, 1'b0);
            if (k == 15) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL burst_locked_after_15 got %0d want 1", locked); end
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL burst_locked_after_16 got %0d want 0", locked); end
        checks++; if (err_count !== 16'd16) begin errors++; $display("FAIL burst_err_count got %0d want 16", err_count); end
        for (int i = 1; i <= 200; i++) begin
            send_bit(1'b0, 1'b0);
            if (locked === 1'b1) begin
                relock = i;
                break;
            end
        end
        nlk = 0;
        checks++; if (relock != 95) begin errors++; $display("FAIL burst_relock_time got %0d want 95 (0 = timeout)", relock); end
        checks++; if (err_count !== 16'd16) begin errors++; $display("FAIL burst_err_held got %0d want 16", err_count); end
    endtask

    task automatic test_all_zero();
        int seen_lock = 0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (locked !== 1'b0) seen_lock++;
            if (err_pulse !== 1'b0) pulses++;
        end
        checks++; if (seen_lock != 0) begin errors++; $display("FAIL zero_locked_cycles got %0d want 0", seen_lock); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL zero_pulses got %0d want 0", pulses); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL zero_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_sparse_valid();
        int lock_at = 0;
        int hold_bad = 0;
        logic last;
        do_reset();
        g = 31'd1;
        for (int i = 1; i <= 200; i++) begin
            send_bit(1'b0, 1'b0);
            last = locked;
            idle();
            if (locked !== last) hold_bad++;
            idle();
            if (locked !== last) hold_bad++;
            if (last === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        nlk = 0;
        checks++; if (lock_at != 95) begin errors++; $display("FAIL sparse_lock_valid_bits got %0d want 95 (0 = timeout)", lock_at); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL sparse_hold got %0d changes want 0", hold_bad); end
        send_bit(1'b1, 1'b1);
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL sparse_clr_wins got %0d want 0", err_count); end
        idle();
        idle();
        send_bit(1'b1, 1'b0);
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL sparse_err_after_clr got %0d want 1", err_count); end
        idle();
        idle();
    endtask

    task automatic test_saturation();
        force dut.u_err_cnt.count_q = 16'hFFFE;
        idle();
        release dut.u_err_cnt.count_q;
        idle();
        checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %0h want fffe", err_count); end
        checks++; if (err_sat !== 1'b0) begin errors++; $display("FAIL sat_flag_preload got %0d want 0", err_sat); end
        send_bit(1'b1, 1'b0);
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first_err got %0h want ffff", err_count); end
        checks++; if (err_sat !== 1'b1) begin errors++; $display("FAIL sat_flag_first got %0d want 1", err_sat); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h want ffff", err_count); end
        checks++; if (err_sat !== 1'b1) begin errors++; $display("FAIL sat_flag_hold got %0d want 1", err_sat); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %0d want 1", locked); end
        // Reset between clock edges must clear outputs without waiting for a clock.
        bit_in  = 1'b1;
        bit_vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midreset_locked got %0d want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL midreset_err_pulse got %0d want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL midreset_err_count got %0d want 0", err_count); end
        checks++; if (err_sat !== 1'b0) begin errors++; $display("FAIL midreset_err_sat got %0d want 0", err_sat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nlk    = 0;
        g      = 31'd1;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_loss();
        test_all_zero();
        test_sparse_valid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
